// File: rtl/iq_response_analyzer_pkg.sv
// iq_response_analyzer_pkg: shared state encoding and default widths for the
// frequency-response demodulator, sweep controller and register map.
package iq_response_analyzer_pkg;
    localparam int WORD_WIDTH   = 16;
    localparam int ACC_WIDTH    = 48;
    localparam int COUNT_WIDTH  = 32;
    localparam int PIPE_LATENCY = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        ACCUM  = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/iq_response_analyzer_mac_lane.sv
// iq_mac_lane: one registered signed multiply-accumulate pipeline
// (input register, product register, accumulate).
module iq_mac_lane
    import iq_response_analyzer_pkg::*;
#(
    parameter int word_width    = WORD_WIDTH,
    parameter int acc_width     = ACC_WIDTH,
    parameter bit offset_binary = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [word_width-1:0] a_i,
    input  logic [word_width-1:0] b_i,
    output logic                  pend_o,
    output logic [acc_width-1:0]  acc_o
);
    localparam logic [word_width-1:0] FLIP = offset_binary ? {1'b1, {(word_width-1){1'b0}}} : '0;

    logic signed [word_width-1:0]   a_q, b_q;
    logic signed [2*word_width-1:0] p_q;
    logic                           v1_q, v2_q;
    logic [acc_width-1:0]           acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            v1_q <= en_i;
            v2_q <= v1_q;
            if (en_i) begin
                a_q <= a_i ^ FLIP;
                b_q <= b_i ^ FLIP;
            end
            if (v1_q) p_q <= a_q * b_q;
            if (clr_i) acc_q <= '0;
            else if (v2_q) acc_q <= acc_q + {{(acc_width-2*word_width){p_q[2*word_width-1]}}, p_q};
        end
    end

    // Only stage 1 is reported: the final product lands in the same edge that ends FLUSH.
    assign pend_o = v1_q;
    assign acc_o  = acc_q;
endmodule

// File: rtl/iq_response_analyzer.sv
// iq_response_analyzer: settles, then coherently demodulates N valid samples
// against the sin/cos reference into I/Q sums with a start/busy/done handshake.
module iq_response_analyzer
    import iq_response_analyzer_pkg::*;
#(
    parameter int word_width    = WORD_WIDTH,
    parameter int acc_width     = ACC_WIDTH,
    parameter int count_width   = COUNT_WIDTH,
    parameter bit offset_binary = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [count_width-1:0] settle_cycles,
    input  logic [count_width-1:0] num_samples,
    input  logic [word_width-1:0]  sample_in,
    input  logic                   sample_valid,
    input  logic [word_width-1:0]  ref_sin,
    input  logic [word_width-1:0]  ref_cos,
    output logic                   busy,
    output logic                   done,
    output logic [acc_width-1:0]   i_acc,
    output logic [acc_width-1:0]   q_acc,
    output logic [count_width-1:0] sample_count
);
    state_t                 state_q;
    logic                   busy_q, done_q;
    logic [count_width-1:0] settle_q, num_q, cnt_q, sample_count_q;
    logic                   pend_i, pend_q;

    logic launch, accept;
    assign launch = start && (state_q == IDLE || state_q == DONE);
    assign accept = (state_q == ACCUM) && sample_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            settle_q       <= '0;
            num_q          <= '0;
            cnt_q          <= '0;
            sample_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    settle_q       <= settle_cycles;
                    num_q          <= num_samples;
                    cnt_q          <= '0;
                    sample_count_q <= '0;
                    state_q        <= settle_cycles != '0 ? SETTLE : num_samples != '0 ? ACCUM : DONE;
                    busy_q         <= settle_cycles != '0 || num_samples != '0;
                    done_q         <= settle_cycles == '0 && num_samples == '0;
                end
                SETTLE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == settle_q - 1'b1) begin
                        state_q <= num_q != '0 ? ACCUM : DONE;
                        busy_q  <= num_q != '0;
                        done_q  <= num_q == '0;
                    end
                end
                ACCUM: if (sample_valid) begin
                    sample_count_q <= sample_count_q + 1'b1;
                    if (sample_count_q + 1'b1 == num_q) state_q <= FLUSH;
                end
                FLUSH: if (!(pend_i || pend_q)) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    iq_mac_lane #(.word_width(word_width), .acc_width(acc_width), .offset_binary(offset_binary)) u_lane_i (
        .clk(clk), .rst(rst), .en_i(accept), .clr_i(launch),
        .a_i(sample_in), .b_i(ref_sin), .pend_o(pend_i), .acc_o(i_acc)
    );

    iq_mac_lane #(.word_width(word_width), .acc_width(acc_width), .offset_binary(offset_binary)) u_lane_q (
        .clk(clk), .rst(rst), .en_i(accept), .clr_i(launch),
        .a_i(sample_in), .b_i(ref_cos), .pend_o(pend_q), .acc_o(q_acc)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = sample_count_q;
endmodule

// File: tb/tb_iq_response_analyzer.sv
// tb_iq_response_analyzer: directed checks of the I/Q demodulator, with a
// second offset-binary instance sharing the same stimulus.
module tb_iq_response_analyzer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] settle_cycles = '0, num_samples = '0;
    logic [15:0] sample_in = '0, ref_sin = '0, ref_cos = '0;
    logic        sample_valid = 1'b0;
    logic        busy, done, busy_ob, done_ob;
    logic [47:0] i_acc, q_acc, i_acc_ob, q_acc_ob;
    logic [31:0] sample_count, sample_count_ob;
    int          tests = 0, fails = 0;
    int          cyc;

    always #5 clk = ~clk;

    iq_response_analyzer dut (
        .clk(clk), .rst(rst), .start(start), .settle_cycles(settle_cycles), .num_samples(num_samples),
        .sample_in(sample_in), .sample_valid(sample_valid), .ref_sin(ref_sin), .ref_cos(ref_cos),
        .busy(busy), .done(done), .i_acc(i_acc), .q_acc(q_acc), .sample_count(sample_count)
    );

    iq_response_analyzer #(.offset_binary(1'b1)) dut_ob (
        .clk(clk), .rst(rst), .start(start), .settle_cycles(settle_cycles), .num_samples(num_samples),
        .sample_in(sample_in), .sample_valid(sample_valid), .ref_sin(ref_sin), .ref_cos(ref_cos),
        .busy(busy_ob), .done(done_ob), .i_acc(i_acc_ob), .q_acc(q_acc_ob), .sample_count(sample_count_ob)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] n);
        settle_cycles = s;
        num_samples   = n;
        start         = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_i", i_acc, 0);
        chk("rst_q", q_acc, 0);
        chk("rst_cnt", sample_count, 0);
        rst = 1'b1;
        tick();

        // DC in-phase: 4 x 0x4000*0x4000
        sample_in = 16'h4000; ref_sin = 16'h4000; ref_cos = 16'h0000; sample_valid = 1'b1;
        run(0, 4);
        chk("dc_busy", busy, 1);
        repeat (4) tick();
        chk("dc_cnt4", sample_count, 4);
        chk("dc_done_early0", done, 0);
        tick();
        chk("dc_done_early1", done, 0);
        tick();
        chk("dc_done", done, 1);
        chk("dc_busy_off", busy, 0);
        chk("dc_i", i_acc, 48'h0000_4000_0000);
        chk("dc_q", q_acc, 0);
        repeat (3) tick();
        chk("dc_extra_ignored", sample_count, 4);
        chk("dc_i_held", i_acc, 48'h0000_4000_0000);

        // Negative/quadrature, started from DONE
        sample_in = 16'hC000; ref_sin = 16'h0000; ref_cos = 16'h7FFF;
        run(0, 2);
        chk("restart_i_cleared", i_acc, 0);
        chk("restart_done_low", done, 0);
        repeat (4) tick();
        chk("neg_done", done, 1);
        chk("neg_q", q_acc, 48'hFFFF_C000_8000);
        chk("neg_i", i_acc, 0);
        chk("neg_cnt", sample_count, 2);

        // Settle with gapped valid; a start pulse while busy must be ignored
        sample_in = 16'h1000; ref_sin = 16'h2000; ref_cos = 16'h1000;
        sample_valid = 1'b0;
        run(10, 3);
        for (int i = 1; i <= 10; i++) begin
            sample_valid = i[0];
            if (i == 4) begin
                start = 1'b1; settle_cycles = 0; num_samples = 1;
            end
            tick();
            start = 1'b0;
            chk("settle_cnt0", sample_count, 0);
            chk("settle_busy", busy, 1);
        end
        chk("settle_i0", i_acc, 0);
        cyc = 0;
        while (!done && cyc < 40) begin
            sample_valid = ~sample_valid;
            tick();
            cyc++;
            if (!done) chk("gap_busy", busy, 1);
        end
        chk("gap_done", done, 1);
        chk("gap_cnt", sample_count, 3);
        chk("gap_i", i_acc, 48'h0000_0600_0000);
        chk("gap_q", q_acc, 48'h0000_0300_0000);

        // Zero-length run: done on the next cycle with zero results
        run(0, 0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_i", i_acc, 0);
        chk("zero_q", q_acc, 0);
        chk("zero_cnt", sample_count, 0);

        // offset_binary: 0xC000 -> +16384, 0x8000 -> 0
        sample_in = 16'hC000; ref_sin = 16'hC000; ref_cos = 16'h8000; sample_valid = 1'b1;
        run(0, 1);
        repeat (3) tick();
        chk("ob_done", done_ob, 1);
        chk("ob_i", i_acc_ob, 48'h0000_1000_0000);
        chk("ob_q", q_acc_ob, 0);
        chk("tc_i", i_acc, 48'h0000_1000_0000);
        chk("tc_q", q_acc, 48'h0000_2000_0000);

        // Asynchronous reset in the middle of a long run
        sample_in = 16'h4000; ref_sin = 16'h4000; ref_cos = 16'h4000;
        run(0, 1000);
        repeat (10) tick();
        chk("mid_cnt10", sample_count, 10);
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_i", i_acc, 0);
        chk("arst_cnt", sample_count, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iq_response_analyzer.md
Name: iq_response_analyzer

Overview:
- Hardware end of the filter frequency-response path: consumes a filter output stream plus the sine_gen sine/cosine reference and coherently demodulates it into I/Q sums.
- Per run: wait a programmable settle time, then accumulate sample×sin (I) and sample×cos (Q) over N valid samples.
- Exposes the results with a start/busy/done handshake, so a sweep controller or host register file can step the period and read gain/phase per point.

Parameters:
- word_width, 16, width of sample_in, ref_sin, ref_cos.
- acc_width, 48, width of the I/Q accumulators.
- count_width, 32, width of settle_cycles, num_samples, sample_count.
- offset_binary, 0, 1 = all three inputs are offset binary (MSB inverted internally to two's complement); 0 = inputs are two's complement.

Ports:
- clk  in  1  system clock (250 MHz domain)
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle run request; sampled only in IDLE or DONE
- settle_cycles  in  count_width  clock cycles to wait before accumulating; latched on start
- num_samples  in  count_width  valid samples to accumulate; latched on start
- sample_in  in  word_width  filter output sample
- sample_valid  in  1  qualifies sample_in
- ref_sin  in  word_width  reference sine, time-aligned with sample_in
- ref_cos  in  word_width  reference cosine, time-aligned with sample_in
- busy  out  1  high in SETTLE, ACCUM, FLUSH
- done  out  1  high in DONE; results stable while high
- i_acc  out  acc_width  signed sum of sample×sin
- q_acc  out  acc_width  signed sum of sample×cos
- sample_count  out  count_width  samples accepted in current/last run

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, i_acc=0, q_acc=0, sample_count=0; pipeline valids cleared.
- Reset mid-run: aborts the run immediately. No partial results are kept.
- IDLE:
  - start=1 latches settle_cycles and num_samples, clears i_acc, q_acc and sample_count, and clears the settle counter.
  - Next state is SETTLE, or ACCUM if settle_cycles=0.
- SETTLE:
  - Counts clock cycles regardless of sample_valid.
  - After exactly settle_cycles cycles, goes to ACCUM.
  - If num_samples=0, goes to DONE instead.
  - If settle_cycles=0 and num_samples=0, start goes directly to DONE with zero results.
- ACCUM:
  - Each cycle with sample_valid=1 accepts one sample and increments sample_count.
  - When sample_count reaches num_samples, goes to FLUSH.
  - Samples arriving after the last accepted one are ignored.
- Pipeline (per accepted sample):
  - Stage 1: register sample, sin and cos, with the offset_binary MSB flip applied.
  - Stage 2: register the two signed word_width×word_width products (2*word_width bits).
  - Stage 3: sign-extend the products to acc_width and add them into i_acc/q_acc.
- FLUSH: waits until the pipeline is empty, then goes to DONE. done rises exactly 3 cycles after the cycle that accepted the last sample.
- DONE:
  - done=1 and the outputs are held.
  - start=1 begins a new run, with the same actions as in IDLE.
  - There is no automatic return to IDLE.
- start while busy=1 is ignored.
- Arithmetic:
  - Two's complement throughout.
  - Accumulators wrap modulo 2^acc_width with no saturation.
  - With the defaults, overflow is impossible for num_samples ≤ 2^16.
- Outputs are registered. There is no combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - state enum (IDLE=0, SETTLE=1, ACCUM=2, FLUSH=3, DONE=4);
  - localparam PIPE_LATENCY=3;
  - the default width constants, reused by the sweep controller and register map.
- One natural sub-module: iq_mac_lane. It holds one signed multiply + accumulate pipeline, with enable, clear and acc_width parameter. It is instantiated twice, once for I and once for Q. The FSM and counters stay in the top.

Test Plan:
- Reset mid-ACCUM:
  - Run with num_samples=1000. Pull rst low after 10 samples.
  - Required: state IDLE, busy=0, i_acc=0, sample_count=0 in the same cycle (async).
- DC in-phase (offset_binary=0):
  - sample_in=0x4000, ref_sin=0x4000, ref_cos=0x0000, sample_valid=1, settle_cycles=0, num_samples=4.
  - Required: i_acc=0x40000000, q_acc=0, sample_count=4.
  - done rises 3 cycles after the 4th sample is accepted.
- Negative/quadrature:
  - sample_in=0xC000 (-16384), ref_sin=0, ref_cos=0x7FFF, num_samples=2.
  - Required: q_acc = 2×(-16384×32767) = -1073709056 (sign-extended to 48 bits), i_acc=0.
- Settle and gaps:
  - settle_cycles=10, num_samples=3, sample_valid toggled 1/0 each cycle.
  - Required: no accumulation for the first 10 cycles after start; exactly 3 samples summed; busy high throughout.
- Edge starts:
  - num_samples=0, settle_cycles=0: done=1 on the cycle after start, with zero results.
  - start pulsed while busy: ignored, and latched values unchanged.
  - start in DONE: restarts with cleared accumulators.
- offset_binary=1:
  - sample_in=0xC000, ref_sin=0xC000 (both +16384), num_samples=1.
  - Required: i_acc=0x10000000.
